// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer
// Purpose  : Memory-stage controller that serializes a LANES-wide vector
//            load/store over the single-word data-memory port, one lane per
//            accepted beat. Scalar accesses share the port while idle.
//            The pipeline is stalled while a vector transfer owns the port.
// Ports    : clk, reset (async, active-low)
//            StartM/VecWriteM/BaseAddrM/StoreDataM - vector instruction in M
//            ScalarReqM/ScalarWeM/ScalarAddrM/ScalarWDataM/ScalarRDataM -
//              scalar memory access
//            MemReq/MemWe/MemAddr/MemWData/MemRData/MemReady - memory port
//            VecMemStallM - stall, VecDoneM - completion pulse,
//            LoadDataM - assembled load vector
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      StartM,
    input  logic                      VecWriteM,
    input  logic [ADDR_W-1:0]         BaseAddrM,
    input  logic [LANES*DATA_W-1:0]   StoreDataM,
    input  logic                      ScalarReqM,
    input  logic                      ScalarWeM,
    input  logic [ADDR_W-1:0]         ScalarAddrM,
    input  logic [DATA_W-1:0]         ScalarWDataM,
    output logic [DATA_W-1:0]         ScalarRDataM,
    output logic                      MemReq,
    output logic                      MemWe,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic [DATA_W-1:0]         MemWData,
    input  logic [DATA_W-1:0]         MemRData,
    input  logic                      MemReady,
    output logic                      VecMemStallM,
    output logic                      VecDoneM,
    output logic [LANES*DATA_W-1:0]   LoadDataM
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BYTES  = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [LANE_W-1:0]         lane;
    logic [ADDR_W-1:0]         base;
    logic                      is_write;
    logic [LANES*DATA_W-1:0]   store_data;
    logic [LANES*DATA_W-1:0]   load_data;

    logic                      last_lane;
    logic [ADDR_W-1:0]         lane_addr;
    logic [DATA_W-1:0]         lane_wdata;

    assign last_lane  = (lane == LANE_W'(LANES - 1));
    // Byte address of the current lane; the add wraps naturally at ADDR_W.
    assign lane_addr  = base + (ADDR_W'(lane) * ADDR_W'(BYTES));
    assign lane_wdata = store_data[lane*DATA_W +: DATA_W];

    assign ScalarRDataM = MemRData;
    assign LoadDataM    = load_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transfer context: latched on start, lane advance and load capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane       <= '0;
            base       <= '0;
            is_write   <= 1'b0;
            store_data <= '0;
            load_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartM) begin
                        base       <= BaseAddrM;
                        is_write   <= VecWriteM;
                        store_data <= StoreDataM;
                        lane       <= '0;
                        if (!VecWriteM) begin
                            load_data <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (MemReady) begin
                        if (!is_write) begin
                            load_data[lane*DATA_W +: DATA_W] <= MemRData;
                        end
                        if (!last_lane) begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and port muxing
    always_comb begin
        state_next   = state;
        MemReq       = 1'b0;
        MemWe        = 1'b0;
        MemAddr      = '0;
        MemWData     = '0;
        VecMemStallM = 1'b0;
        VecDoneM     = 1'b0;
        case (state)
            IDLE: begin
                MemAddr  = ScalarAddrM;
                MemWData = ScalarWDataM;
                if (StartM) begin
                    // Vector wins over a coincident scalar request.
                    VecMemStallM = 1'b1;
                    state_next   = ACCESS;
                end else begin
                    MemReq = ScalarReqM;
                    MemWe  = ScalarWeM;
                end
            end
            ACCESS: begin
                VecMemStallM = 1'b1;
                MemReq       = 1'b1;
                MemWe        = is_write;
                MemAddr      = lane_addr;
                MemWData     = lane_wdata;
                if (MemReady && last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // StartM is still high here for the same instruction; ignore it.
                VecDoneM   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // While reset is asserted the port is silent even if scalar inputs are active.
        if (!reset) begin
            MemReq       = 1'b0;
            MemWe        = 1'b0;
            MemAddr      = '0;
            MemWData     = '0;
            VecMemStallM = 1'b0;
            VecDoneM     = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Purpose  : Self-checking bench for vec_mem_sequencer with a behavioural
//            memory/transfer model and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              StartM, VecWriteM;
    logic [ADDR_W-1:0] BaseAddrM;
    logic [VW-1:0]     StoreDataM;
    logic              ScalarReqM, ScalarWeM;
    logic [ADDR_W-1:0] ScalarAddrM;
    logic [DATA_W-1:0] ScalarWDataM;
    logic [DATA_W-1:0] ScalarRDataM;
    logic              MemReq, MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemReady;
    logic              VecMemStallM, VecDoneM;
    logic [VW-1:0]     LoadDataM;

    int            n_vec = 0;
    int            n_err = 0;
    logic [VW-1:0] last_load = '0;

    always #5 clk = ~clk;

    // Memory content is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign MemRData = mem_word(MemAddr);

    vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .StartM(StartM), .VecWriteM(VecWriteM),
        .BaseAddrM(BaseAddrM), .StoreDataM(StoreDataM),
        .ScalarReqM(ScalarReqM), .ScalarWeM(ScalarWeM),
        .ScalarAddrM(ScalarAddrM), .ScalarWDataM(ScalarWDataM),
        .ScalarRDataM(ScalarRDataM), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
        .MemReady(MemReady), .VecMemStallM(VecMemStallM),
        .VecDoneM(VecDoneM), .LoadDataM(LoadDataM)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One vector instruction: StartM stays high from the start cycle through DONE.
    task automatic vec_op(input bit wr, input logic [31:0] base, input bit rnd_ready,
                          input int hold_lane, input int hold_len);
        logic [VW-1:0] sv;
        logic [VW-1:0] exp_ld;
        logic [31:0]   exp_addr;
        int            i, waited, acc_cycles, stalls;
        sv           = rand_vec();
        StartM       = 1'b1;
        VecWriteM    = wr;
        BaseAddrM    = base;
        StoreDataM   = sv;
        ScalarReqM   = 1'b1;
        ScalarWeM    = 1'($urandom);
        ScalarAddrM  = $urandom;
        ScalarWDataM = $urandom;
        MemReady     = 1'($urandom);
        exp_ld       = wr ? last_load : '0;
        @(negedge clk);
        check("start_stall", 128'(VecMemStallM), 128'(1));
        check("start_req_masked", 128'(MemReq), 128'(0));
        check("start_done", 128'(VecDoneM), 128'(0));
        stalls = int'(VecMemStallM);
        @(posedge clk); #1;
        // Scramble instruction inputs: the transfer must use latched values.
        BaseAddrM  = $urandom;
        StoreDataM = rand_vec();
        VecWriteM  = ~wr;
        ScalarReqM = 1'b0;
        i = 0; waited = 0; acc_cycles = 0;
        while (i < LANES && acc_cycles < 200) begin
            if (rnd_ready) begin
                MemReady = ($urandom_range(0, 2) != 0);
            end else if (i == hold_lane && waited < hold_len) begin
                MemReady = 1'b0;
                waited++;
            end else begin
                MemReady = 1'b1;
            end
            @(negedge clk);
            acc_cycles++;
            stalls += int'(VecMemStallM);
            exp_addr = base + 32'(i * 4);
            check("acc_stall", 128'(VecMemStallM), 128'(1));
            check("acc_req", 128'(MemReq), 128'(1));
            check("acc_we", 128'(MemWe), 128'(wr));
            check("acc_addr", 128'(MemAddr), 128'(exp_addr));
            if (wr) check("acc_wdata", 128'(MemWData), 128'(sv[i*32 +: 32]));
            check("acc_done", 128'(VecDoneM), 128'(0));
            check("acc_loaddata", LoadDataM, exp_ld);
            if (MemReady) begin
                if (!wr) exp_ld[i*32 +: 32] = mem_word(exp_addr);
                i++;
            end
            @(posedge clk); #1;
        end
        if (i < LANES) check("transfer_timeout", 128'(i), 128'(LANES));
        MemReady = 1'($urandom);
        @(negedge clk);
        check("done_pulse", 128'(VecDoneM), 128'(1));
        check("done_stall", 128'(VecMemStallM), 128'(0));
        check("done_req", 128'(MemReq), 128'(0));
        check("done_loaddata", LoadDataM, exp_ld);
        check("stall_cycles", 128'(stalls), 128'(1 + acc_cycles));
        last_load = exp_ld;
        @(posedge clk); #1;
        StartM     = 1'b0;
        ScalarReqM = 1'b0;
    endtask

    task automatic scalar_op(input logic [31:0] a);
        logic we;
        logic [31:0] wd;
        we           = 1'($urandom);
        wd           = $urandom;
        StartM       = 1'b0;
        ScalarReqM   = 1'b1;
        ScalarWeM    = we;
        ScalarAddrM  = a;
        ScalarWDataM = wd;
        MemReady     = 1'b1;
        @(negedge clk);
        check("scalar_req", 128'(MemReq), 128'(1));
        check("scalar_we", 128'(MemWe), 128'(we));
        check("scalar_addr", 128'(MemAddr), 128'(a));
        check("scalar_wdata", 128'(MemWData), 128'(wd));
        check("scalar_stall", 128'(VecMemStallM), 128'(0));
        check("scalar_rdata", 128'(ScalarRDataM), 128'(mem_word(a)));
        check("scalar_loadhold", LoadDataM, last_load);
        @(posedge clk); #1;
        ScalarReqM = 1'b0;
    endtask

    task automatic idle_cycle();
        StartM     = 1'b0;
        ScalarReqM = 1'b0;
        MemReady   = 1'($urandom);
        @(negedge clk);
        check("idle_done", 128'(VecDoneM), 128'(0));
        check("idle_stall", 128'(VecMemStallM), 128'(0));
        check("idle_req", 128'(MemReq), 128'(0));
        @(posedge clk); #1;
    endtask

    // Abort a load while lane 2 is on the port.
    task automatic reset_mid();
        StartM     = 1'b1;
        VecWriteM  = 1'b0;
        BaseAddrM  = 32'h300;
        ScalarReqM = 1'b0;
        MemReady   = 1'b0;
        @(posedge clk); #1;
        MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MemReady = 1'b0;
        @(negedge clk);
        check("pre_reset_addr", 128'(MemAddr), 128'(32'h308));
        #1;
        ScalarReqM = 1'b1;
        reset      = 1'b0;
        #1;
        check("rst_req", 128'(MemReq), 128'(0));
        check("rst_we", 128'(MemWe), 128'(0));
        check("rst_stall", 128'(VecMemStallM), 128'(0));
        check("rst_done", 128'(VecDoneM), 128'(0));
        check("rst_addr", 128'(MemAddr), 128'(0));
        check("rst_wdata", 128'(MemWData), 128'(0));
        check("rst_loaddata", LoadDataM, 128'(0));
        StartM     = 1'b0;
        ScalarReqM = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        last_load = '0;
        for (int k = 0; k < 4; k++) idle_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        StartM       = 1'b0;
        VecWriteM    = 1'b0;
        BaseAddrM    = '0;
        StoreDataM   = '0;
        ScalarReqM   = 1'b0;
        ScalarWeM    = 1'b0;
        ScalarAddrM  = '0;
        ScalarWDataM = '0;
        MemReady     = 1'b0;
        #2;
        check("reset_req", 128'(MemReq), 128'(0));
        check("reset_stall", 128'(VecMemStallM), 128'(0));
        check("reset_done", 128'(VecDoneM), 128'(0));
        check("reset_loaddata", LoadDataM, 128'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle_cycle();

        vec_op(1'b0, 32'h100, 1'b0, -1, 0);         // load, always ready
        vec_op(1'b1, 32'h200, 1'b0, 1, 2);          // store, 2 wait cycles on lane 1
        vec_op(1'b0, 32'hFFFF_FFF8, 1'b0, -1, 0);   // address wrap
        scalar_op(32'h40);
        reset_mid();
        vec_op(1'b0, 32'h500, 1'b0, -1, 0);         // back-to-back pair
        vec_op(1'b1, 32'h600, 1'b1, -1, 0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: scalar_op($urandom);
                1: vec_op(1'b0, $urandom & 32'hFFFF_FFFC, 1'b1, -1, 0);
                2: vec_op(1'b1, $urandom & 32'hFFFF_FFFC, 1'b1, -1, 0);
                default: idle_cycle();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
